// File: rtl/dmem_initiator.sv
// dmem_initiator: M-stage load/store initiator for the 1024-word data memory (IDLE -> WAIT -> RESP).
// Optional DMEM_TIMEOUT_EN aborts a WAIT that sees no mem_ack for TIMEOUT cycles.
module dmem_initiator #(
  parameter int MEM_DEPTH = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  output logic        mem_we,
  output logic        mem_re,
  input  logic        mem_ack,
  input  logic [63:0] mem_q,
  input  logic        mem_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      r_state;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic        r_mem_we;
  logic        r_mem_re;
  logic [63:0] r_rsp_rdata;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_data;

  logic w_bad;
  logic w_reject;

  // Conflicting strobes and out-of-range addresses are errors; an empty request is a clean no-op.
  assign w_bad    = (req_read & req_write) | (req_addr >= 64'(MEM_DEPTH));
  assign w_reject = w_bad | (~req_read & ~req_write);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_timeout;
  logic             w_expire;
  assign w_expire    = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign rsp_timeout = r_rsp_timeout;
`else
  // Constant 0: no timeout logic exists in this build.
  assign rsp_timeout = (TIMEOUT < 0);
`endif

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
`ifdef DMEM_TIMEOUT_EN
      r_cnt         <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_reject) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_bad;
              r_rsp_rdata <= '0;
`ifdef DMEM_TIMEOUT_EN
              r_rsp_timeout <= 1'b0;
`endif
              r_state     <= S_RESP;
            end else begin
              r_mem_addr <= req_addr;
              r_mem_data <= req_wdata;
              r_mem_we   <= req_write;
              r_mem_re   <= req_read;
`ifdef DMEM_TIMEOUT_EN
              r_cnt      <= '0;
`endif
              r_state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_mem_re ? mem_q : 64'd0;
            r_rsp_err   <= mem_err;
`ifdef DMEM_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
            r_state     <= S_RESP;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (w_expire) begin
            r_mem_we      <= 1'b0;
            r_mem_re      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_cnt         <= r_cnt + CNT_W'(1);
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: directed scenarios plus randomized traffic against a request-level reference model.
module tb_dmem_initiator;
  localparam int DEPTH = 1024;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_read, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [63:0] rsp_rdata, mem_addr, mem_data, mem_q;
  logic        mem_we, mem_re, mem_ack, mem_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] mem_arr   [0:DEPTH-1];
  logic [63:0] model_mem [0:DEPTH-1];

  always #5 clk = ~clk;

  dmem_initiator #(.MEM_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_re(mem_re),
    .mem_ack(mem_ack), .mem_q(mem_q), .mem_err(mem_err)
  );

  typedef struct {
    int          lat;
    int          n_re;
    int          n_we;
    int          bad_port;
    int          bad_ready;
    logic [63:0] rdata;
    logic        err;
    logic        tmo;
    logic        ready_after;
    logic [63:0] addr_at_rsp;
  } obs_t;

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Issue one request and play the memory: ack on the (dly+1)-th strobe cycle.
  task automatic drive(input bit rd, input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                       input int dly, input bit merr, output obs_t o);
    int k;
    bit got;
    o.lat = -1; o.n_re = 0; o.n_we = 0; o.bad_port = 0; o.bad_ready = 0;
    o.rdata = 'x; o.err = 1'bx; o.tmo = 1'bx; o.ready_after = 1'b0; o.addr_at_rsp = 'x;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1));
      mem_err = 1'($urandom_range(0, 1));
      mem_q   = r64();
      if (req_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_wait: req_ready stayed %b, required 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_read = 1'($urandom); req_write = 1'($urandom);
    req_addr = r64(); req_wdata = r64();
    k = 0;
    for (int c = 1; c <= 64 && o.lat < 0; c++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) o.bad_ready++;
      if (rsp_valid === 1'b1) begin
        o.lat = c; o.rdata = rsp_rdata; o.err = rsp_err; o.tmo = rsp_timeout;
        o.addr_at_rsp = mem_addr;
        if (mem_re || mem_we) o.bad_port++;
        mem_ack = 1'($urandom_range(0, 1));
      end else if (mem_re || mem_we) begin
        if (mem_re) o.n_re++;
        if (mem_we) o.n_we++;
        if (mem_addr !== addr || mem_data !== wdata || mem_re !== rd || mem_we !== wr) o.bad_port++;
        k++;
        if (k == dly + 1) begin
          mem_ack = 1'b1;
          mem_err = merr;
          mem_q   = mem_arr[mem_addr[9:0]];
          if (mem_we) mem_arr[mem_addr[9:0]] = mem_data;
        end else begin
          mem_ack = 1'b0; mem_err = 1'($urandom); mem_q = r64();
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1)); mem_err = 1'($urandom); mem_q = r64();
      end
    end
    @(negedge clk);
    o.ready_after = req_ready;
    mem_ack = 1'b0; mem_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_read = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    mem_ack = 0; mem_q = '0; mem_err = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, mem_we, mem_re} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000", {rsp_valid, rsp_err, rsp_timeout, mem_we, mem_re}); end
    n_cmp++; if (rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
    n_cmp++; if (mem_addr !== 64'd0 || mem_data !== 64'd0) begin
      n_fail++; $display("FAIL reset_mem_bus: addr %h data %h required 0", mem_addr, mem_data); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_write();
    obs_t o;
    drive(1'b0, 1'b1, 64'd5, 64'hDEADBEEF, 0, 1'b0, o);
    model_mem[5] = 64'hDEADBEEF;
    n_cmp++; if (o.n_we != 1 || o.n_re != 0) begin n_fail++; $display("FAIL wr_strobe: we %0d re %0d required 1/0", o.n_we, o.n_re); end
    n_cmp++; if (o.bad_port != 0) begin n_fail++; $display("FAIL wr_port: %0d bad cycles required 0", o.bad_port); end
    n_cmp++; if (o.lat != 2) begin n_fail++; $display("FAIL wr_latency: got %0d required 2", o.lat); end
    n_cmp++; if (o.err !== 1'b0 || o.tmo !== 1'b0) begin n_fail++; $display("FAIL wr_err: err %b tmo %b required 0/0", o.err, o.tmo); end
    n_cmp++; if (o.ready_after !== 1'b1 || o.bad_ready != 0) begin
      n_fail++; $display("FAIL wr_ready: after %b busy-high %0d required 1/0", o.ready_after, o.bad_ready); end
  endtask

  task automatic test_read_delayed();
    obs_t o;
    drive(1'b1, 1'b0, 64'd5, r64(), 3, 1'b0, o);
    n_cmp++; if (o.n_re != 4 || o.n_we != 0) begin n_fail++; $display("FAIL rd_strobe: re %0d we %0d required 4/0", o.n_re, o.n_we); end
    n_cmp++; if (o.lat != 5) begin n_fail++; $display("FAIL rd_latency: got %0d required 5", o.lat); end
    n_cmp++; if (o.rdata !== 64'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h required deadbeef", o.rdata); end
    n_cmp++; if (o.err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b required 0", o.err); end
    n_cmp++; if (o.addr_at_rsp !== 64'd5) begin n_fail++; $display("FAIL rd_addr_hold: got %h required 5", o.addr_at_rsp); end
  endtask

  task automatic test_oob();
    obs_t o;
    drive(1'b1, 1'b0, 64'd1024, r64(), 0, 1'b0, o);
    n_cmp++; if (o.n_re != 0 || o.n_we != 0) begin n_fail++; $display("FAIL oob_strobe: re %0d we %0d required 0/0", o.n_re, o.n_we); end
    n_cmp++; if (o.lat != 1) begin n_fail++; $display("FAIL oob_latency: got %0d required 1", o.lat); end
    n_cmp++; if (o.err !== 1'b1) begin n_fail++; $display("FAIL oob_err: got %b required 1", o.err); end
  endtask

  task automatic test_both_set();
    obs_t o;
    drive(1'b1, 1'b1, 64'd7, r64(), 0, 1'b0, o);
    n_cmp++; if (o.n_re + o.n_we != 0) begin n_fail++; $display("FAIL both_strobe: %0d strobe cycles required 0", o.n_re + o.n_we); end
    n_cmp++; if (o.lat != 1 || o.err !== 1'b1) begin n_fail++; $display("FAIL both_rsp: lat %0d err %b required 1/1", o.lat, o.err); end
  endtask

  task automatic test_mem_err();
    obs_t o;
    drive(1'b1, 1'b0, 64'd9, r64(), 1, 1'b1, o);
    n_cmp++; if (o.n_re != 2) begin n_fail++; $display("FAIL merr_strobe: re %0d required 2", o.n_re); end
    n_cmp++; if (o.lat != 3 || o.err !== 1'b1) begin n_fail++; $display("FAIL merr_rsp: lat %0d err %b required 3/1", o.lat, o.err); end
  endtask

  task automatic test_noop();
    obs_t o;
    drive(1'b0, 1'b0, 64'd3, r64(), 0, 1'b0, o);
    n_cmp++; if (o.lat != 1 || o.err !== 1'b0 || o.rdata !== 64'd0 || o.n_re + o.n_we != 0) begin
      n_fail++; $display("FAIL noop_rsp: lat %0d err %b rdata %h strobes %0d required 1/0/0/0", o.lat, o.err, o.rdata, o.n_re + o.n_we); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      int sel, dly, exp_lat, exp_re, exp_we;
      bit rd, wr, merr, oob, reject, access;
      logic [63:0] addr, wdata, exp_rdata;
      logic exp_err;
      sel = $urandom_range(0, 9);
      rd = (sel == 0) || (sel >= 2 && sel <= 5);
      wr = (sel == 0) || (sel >= 6);
      oob = ($urandom_range(0, 7) == 0);
      addr = oob ? (($urandom_range(0, 1) == 1) ? 64'(DEPTH + $urandom_range(0, 3)) : (r64() | 64'h8000_0000_0000_0000))
                 : 64'($urandom_range(0, 15));
      wdata = r64();
      dly = $urandom_range(0, 4);
      merr = rd && !wr && ($urandom_range(0, 4) == 0);
      reject = (rd && wr) || oob;
      access = !reject && (rd || wr);
      exp_lat = access ? dly + 2 : 1;
      exp_re = (access && rd) ? dly + 1 : 0;
      exp_we = (access && wr) ? dly + 1 : 0;
      exp_err = reject ? 1'b1 : (access ? merr : 1'b0);
      exp_rdata = (access && rd) ? model_mem[addr[9:0]] : 64'd0;
      drive(rd, wr, addr, wdata, dly, merr, o);
      if (access && wr) model_mem[addr[9:0]] = wdata;
      n_cmp++; if (o.lat != exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d required %0d", i, o.lat, exp_lat); end
      n_cmp++; if (o.n_re != exp_re || o.n_we != exp_we) begin
        n_fail++; $display("FAIL rnd%0d_strobes: re %0d we %0d required %0d/%0d", i, o.n_re, o.n_we, exp_re, exp_we); end
      n_cmp++; if (o.bad_port != 0 || o.bad_ready != 0) begin
        n_fail++; $display("FAIL rnd%0d_port: bad %0d ready-high %0d required 0/0", i, o.bad_port, o.bad_ready); end
      n_cmp++; if (o.err !== exp_err || o.tmo !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_err: err %b tmo %b required %b/0", i, o.err, o.tmo, exp_err); end
      n_cmp++; if (o.ready_after !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready: got %b required 1", i, o.ready_after); end
      if (!reject) begin
        n_cmp++; if (o.rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h required %h", i, o.rdata, exp_rdata); end
      end
      if (access) begin
        n_cmp++; if (o.addr_at_rsp !== addr) begin n_fail++; $display("FAIL rnd%0d_addr_hold: got %h required %h", i, o.addr_at_rsp, addr); end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 64'd11; req_wdata = r64();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: mem_re %b required 1", mem_re); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_drop: re %b we %b required 0/0", mem_re, mem_we); end
    seen = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid !== 1'b0) seen++; end
    #2 rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0) seen++; end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_rsp: %0d rsp_valid cycles required 0", seen); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b required 1", req_ready); end
    drive(1'b1, 1'b0, 64'd11, r64(), 1, 1'b0, o);
    n_cmp++; if (o.lat != 3 || o.err !== 1'b0 || o.rdata !== model_mem[11]) begin
      n_fail++; $display("FAIL rstmid_next: lat %0d err %b rdata %h required 3/0/%h", o.lat, o.err, o.rdata, model_mem[11]); end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    drive(1'b1, 1'b0, 64'd2, r64(), 1000, 1'b0, o);
    n_cmp++; if (o.n_re != TMO) begin n_fail++; $display("FAIL tmo_strobe: re %0d required %0d", o.n_re, TMO); end
    n_cmp++; if (o.lat != TMO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d required %0d", o.lat, TMO + 1); end
    n_cmp++; if (o.err !== 1'b1 || o.tmo !== 1'b1 || o.rdata !== 64'd0) begin
      n_fail++; $display("FAIL tmo_rsp: err %b tmo %b rdata %h required 1/1/0", o.err, o.tmo, o.rdata); end
    n_cmp++; if (o.ready_after !== 1'b1) begin n_fail++; $display("FAIL tmo_ready: got %b required 1", o.ready_after); end
    drive(1'b1, 1'b0, 64'd5, r64(), TMO - 1, 1'b0, o);
    n_cmp++; if (o.lat != TMO + 1 || o.tmo !== 1'b0 || o.err !== 1'b0 || o.rdata !== model_mem[5]) begin
      n_fail++; $display("FAIL tmo_ackwins: lat %0d tmo %b err %b rdata %h required %0d/0/0/%h", o.lat, o.tmo, o.err, o.rdata, TMO + 1, model_mem[5]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = 64'd0;
      model_mem[i] = 64'd0;
    end
    test_reset();
    test_write();
    test_read_delayed();
    test_oob();
    test_both_set();
    test_mem_err();
    test_noop();
    test_random();
    test_reset_mid();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/dmem_initiator.md
Name: dmem_initiator

Overview:
- Memory-stage load/store initiator for the Y86 pipeline. It drives the data-memory port on behalf of the M stage.
- It accepts one request per handshake from the M stage, checks the address bound, and issues read or write strobes to the data memory.
- It waits for the memory acknowledge, then returns read data and error status to the M stage as a one-cycle response.
- It sits between the M-stage control logic and the 1024-word data memory. It is the initiator side of the memory's addr/data/we/re/q/dmem_error interface.

Parameters:
- MEM_DEPTH, 1024, number of 64-bit words in data memory; addresses are word indices.
- TIMEOUT, 16, maximum cycles spent in WAIT before abort; only used when DMEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  M stage presents a request.
- req_ready  output  1  initiator can accept a request.
- req_read  input  1  request is a load (mrmovq, popq, ret).
- req_write  input  1  request is a store (rmmovq, pushq, call).
- req_addr  input  64  word address.
- req_wdata  input  64  store data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  64  load result.
- rsp_err  output  1  SADR-class error for this response.
- rsp_timeout  output  1  response was aborted by timeout.
- mem_addr  output  64  address to memory.
- mem_data  output  64  write data to memory.
- mem_we  output  1  write strobe.
- mem_re  output  1  read strobe.
- mem_ack  input  1  memory has completed the access this cycle.
- mem_q  input  64  memory read data, valid when mem_ack=1.
- mem_err  input  1  memory-reported error (dmem_error), sampled with mem_ack.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All state is updated on the rising edge of clk.
- Reset state:
  - FSM in IDLE.
  - rsp_valid, rsp_err, rsp_timeout, mem_we and mem_re are 0.
  - rsp_rdata, mem_addr and mem_data are 0.
  - The timeout counter is 0.
  - When rst_n falls mid-access, the strobes clear immediately and any in-flight request is dropped without a response.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1; it is 0 in every other state.
  - A request is accepted on the edge where req_valid=1 and req_ready=1.
  - The request's fields are registered on acceptance. req_* inputs are ignored while not in IDLE.
- Accept decode, in priority order:
  - req_read=1 and req_write=1: no memory access; go to RESP with rsp_err=1.
  - req_addr >= MEM_DEPTH: no memory strobe; go to RESP with rsp_err=1.
  - Neither req_read nor req_write set: no access; go to RESP with rsp_err=0 and rsp_rdata=0.
  - Otherwise: go to WAIT, with mem_addr=req_addr, mem_data=req_wdata, and mem_we=req_write or mem_re=req_read.
- WAIT:
  - Strobes, mem_addr and mem_data are held stable until an edge where mem_ack=1.
  - On that edge: strobes clear to 0.
  - On a read, rsp_rdata is loaded with mem_q. On a write, rsp_rdata is loaded with 0.
  - rsp_err is loaded with mem_err, then the FSM goes to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then the FSM returns to IDLE.
  - rsp_rdata, rsp_err and rsp_timeout hold their values until the next response is loaded.
- Latency:
  - Request accepted at edge N; strobes are high during cycle N+1.
  - If mem_ack=1 in cycle N+1, rsp_valid is high during cycle N+2 and req_ready is high again during cycle N+3.
  - Each extra cycle without mem_ack adds one cycle.
  - A request that fails the bound check responds at cycle N+1.
- Maximum throughput is one access per 3 cycles.
- mem_ack is ignored outside WAIT.
- mem_addr and mem_data keep their last value after the strobes drop.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - A counter, wide enough to hold TIMEOUT, clears on entry to WAIT and increments each WAIT cycle without mem_ack.
  - When the count reaches TIMEOUT with no ack, strobes clear, rsp_err=1, rsp_timeout=1, rsp_rdata=0, and the FSM goes to RESP.
  - If mem_ack arrives on the same edge that the count reaches TIMEOUT, the ack wins.
- Not defined:
  - No counter is built; WAIT persists indefinitely.
  - rsp_timeout is tied to 0.

Test Plan:
- Reset, then a write with addr=5 and wdata=0xDEADBEEF, with the memory acking in the first WAIT cycle.
  - Required: mem_we=1 for exactly one cycle with mem_addr=5.
  - Required: rsp_valid=1 at cycle N+2 with rsp_err=0.
- Read with addr=5 following the write above, with mem_ack delayed 3 cycles and mem_q=0xDEADBEEF.
  - Required: mem_re is held for 4 cycles.
  - Required: rsp_rdata=0xDEADBEEF and rsp_err=0, with rsp_valid at cycle N+5.
- Read with addr=1024.
  - Required: mem_re never asserts.
  - Required: rsp_valid at N+1 with rsp_err=1.
- Read and write both set, and separately a read with mem_err=1 asserted alongside mem_ack.
  - Required: rsp_err=1 in both cases; only the second case produces a strobe.
- With DMEM_TIMEOUT_EN defined and TIMEOUT=16, a read where mem_ack is never asserted.
  - Required: the strobe drops after 16 WAIT cycles.
  - Required: rsp_valid with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
  - Required: req_ready returns high afterwards.
- rst_n asserted low for 2 cycles during WAIT.
  - Required: mem_re drops immediately and no rsp_valid is produced.
  - Required: after rst_n releases, req_ready=1 and the next read completes normally.
